// File: rtl/seven_seg_scanner.sv
// Time-multiplexed driver for a 4-digit common-anode 7-segment display.
// Active-low anodes/segments, with a blanking gap before each digit slot.
module seven_seg_scanner #(
    parameter int DWELL_CYCLES = 50000,
    parameter int BLANK_CYCLES = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [15:0] value,
    input  logic [3:0]  digit_en,
    input  logic [3:0]  dp_in,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);

    localparam int MAX_CYCLES = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [1:0]     idx_q, idx_d;
    logic [15:0]    shadow_q, shadow_d;
    logic [15:0]    disp_q, disp_d;
    logic [3:0]     an_q, an_d;
    logic [6:0]     seg_q, seg_d;
    logic           dp_q, dp_d;
    logic [3:0]     nib;

    function automatic logic [6:0] hexdec(input logic [3:0] h);
        case (h)
            4'h0: hexdec = 7'b1000000;
            4'h1: hexdec = 7'b1111001;
            4'h2: hexdec = 7'b0100100;
            4'h3: hexdec = 7'b0110000;
            4'h4: hexdec = 7'b0011001;
            4'h5: hexdec = 7'b0010010;
            4'h6: hexdec = 7'b0000010;
            4'h7: hexdec = 7'b1111000;
            4'h8: hexdec = 7'b0000000;
            4'h9: hexdec = 7'b0010000;
            4'hA: hexdec = 7'b0001000;
            4'hB: hexdec = 7'b0000011;
            4'hC: hexdec = 7'b1000110;
            4'hD: hexdec = 7'b0100001;
            4'hE: hexdec = 7'b0000110;
            default: hexdec = 7'b0001110;
        endcase
    endfunction

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + CW'(1);
        idx_d    = idx_q;
        shadow_d = load ? value : shadow_q;
        disp_d   = disp_q;
        an_d     = an_q;
        seg_d    = seg_q;
        dp_d     = dp_q;
        nib      = 4'h0;

        case (state_q)
            ST_BLANK: begin
                if (cnt_q == CW'(BLANK_CYCLES - 1)) begin
                    state_d = ST_SHOW;
                    cnt_d   = '0;
                    // Frame boundary: a load on this very edge bypasses the shadow
                    if (idx_q == 2'd0) begin
                        disp_d = load ? value : shadow_q;
                    end
                    case (idx_q)
                        2'd0:    nib = disp_d[3:0];
                        2'd1:    nib = disp_d[7:4];
                        2'd2:    nib = disp_d[11:8];
                        default: nib = disp_d[15:12];
                    endcase
                    if (digit_en[idx_q]) begin
                        an_d  = ~(4'b0001 << idx_q);
                        seg_d = hexdec(nib);
                        dp_d  = ~dp_in[idx_q];
                    end else begin
                        an_d  = 4'b1111;
                        seg_d = 7'h7F;
                        dp_d  = 1'b1;
                    end
                end
            end
            default: begin
                if (cnt_q == CW'(DWELL_CYCLES - 1)) begin
                    state_d = ST_BLANK;
                    cnt_d   = '0;
                    idx_d   = idx_q + 2'd1;
                    an_d    = 4'b1111;
                    seg_d   = 7'h7F;
                    dp_d    = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_BLANK;
            cnt_q    <= '0;
            idx_q    <= 2'd0;
            shadow_q <= 16'h0000;
            disp_q   <= 16'h0000;
            an_q     <= 4'b1111;
            seg_q    <= 7'h7F;
            dp_q     <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            shadow_q <= shadow_d;
            disp_q   <= disp_d;
            an_q     <= an_d;
            seg_q    <= seg_d;
            dp_q     <= dp_d;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;
    assign dp  = dp_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Directed, table-driven bench for seven_seg_scanner with DWELL=3, BLANK=1 (16-clk frame).
module tb_seven_seg_scanner;

    logic        clk = 1'b0;
    logic        reset;
    logic        load;
    logic [15:0] value;
    logic [3:0]  digit_en;
    logic [3:0]  dp_in;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;

    int errors = 0;
    int checks = 0;

    localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100, S3 = 7'b0110000;
    localparam logic [6:0] S4 = 7'b0011001, S5 = 7'b0010010, S6 = 7'b0000010, S7 = 7'b1111000;
    localparam logic [6:0] S8 = 7'b0000000, S9 = 7'b0010000, SA = 7'b0001000, SB = 7'b0000011;
    localparam logic [6:0] SC = 7'b1000110, SD = 7'b0100001, SE = 7'b0000110, SF = 7'b0001110;
    localparam logic [6:0] OFF = 7'h7F;

    typedef struct {
        logic        ld;
        logic [15:0] val;
        logic [3:0]  en;
        logic [3:0]  dpi;
        logic [3:0]  e_an;
        logic [6:0]  e_seg;
        logic        e_dp;
    } vec_t;

    vec_t vecs[$];

    seven_seg_scanner #(.DWELL_CYCLES(3), .BLANK_CYCLES(1)) dut (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .value    (value),
        .digit_en (digit_en),
        .dp_in    (dp_in),
        .an       (an),
        .seg      (seg),
        .dp       (dp)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got an/seg/dp=%b/%b/%b want %b/%b/%b", name,
                     act[11:8], act[7:1], act[0], exp_v[11:8], exp_v[7:1], exp_v[0]);
        end
    endtask

    // One slot = entry edge + 2 lit edges + 1 blanking edge; enables are flipped
    // after the entry edge to show they are only sampled there.
    task automatic add_slot(input logic ld, input logic [15:0] val, input logic [3:0] en,
                            input logic [3:0] dpi, input logic [3:0] ean,
                            input logic [6:0] eseg, input logic edp);
        vec_t v;
        v = '{ld, val, en, dpi, ean, eseg, edp};
        vecs.push_back(v);
        v = '{1'b0, val, ~en, ~dpi, ean, eseg, edp};
        vecs.push_back(v);
        vecs.push_back(v);
        v = '{1'b0, val, en, dpi, 4'b1111, OFF, 1'b1};
        vecs.push_back(v);
    endtask

    initial begin
        int zeros;

        // Frame 1: load at the frame-start edge is shown immediately
        add_slot(1'b1, 16'h1A8F, 4'hF, 4'h0, 4'b1110, SF, 1'b1);
        add_slot(1'b0, 16'h0000, 4'hF, 4'h0, 4'b1101, S8, 1'b1);
        add_slot(1'b0, 16'h0000, 4'hF, 4'h0, 4'b1011, SA, 1'b1);
        add_slot(1'b0, 16'h0000, 4'hF, 4'h0, 4'b0111, S1, 1'b1);
        // Frame 2: mid-frame load of 0 must not tear the frame
        add_slot(1'b0, 16'h0000, 4'hF, 4'h0, 4'b1110, SF, 1'b1);
        add_slot(1'b1, 16'h0000, 4'hF, 4'h0, 4'b1101, S8, 1'b1);
        add_slot(1'b0, 16'h0000, 4'hF, 4'h0, 4'b1011, SA, 1'b1);
        add_slot(1'b0, 16'h0000, 4'hF, 4'h0, 4'b0111, S1, 1'b1);
        // Frame 3: the new value appears
        add_slot(1'b0, 16'h0000, 4'hF, 4'h0, 4'b1110, S0, 1'b1);
        add_slot(1'b0, 16'h0000, 4'hF, 4'h0, 4'b1101, S0, 1'b1);
        add_slot(1'b0, 16'h0000, 4'hF, 4'h0, 4'b1011, S0, 1'b1);
        add_slot(1'b0, 16'h0000, 4'hF, 4'h0, 4'b0111, S0, 1'b1);
        // Frame 4: digits 1 and 3 disabled, slot time kept
        add_slot(1'b0, 16'h0000, 4'b0101, 4'h0, 4'b1110, S0, 1'b1);
        add_slot(1'b0, 16'h0000, 4'b0101, 4'h0, 4'b1111, OFF, 1'b1);
        add_slot(1'b0, 16'h0000, 4'b0101, 4'h0, 4'b1011, S0, 1'b1);
        add_slot(1'b0, 16'h0000, 4'b0101, 4'h0, 4'b1111, OFF, 1'b1);
        // Frame 5: decimal point on digit 1 only
        add_slot(1'b0, 16'h0000, 4'hF, 4'b0010, 4'b1110, S0, 1'b1);
        add_slot(1'b0, 16'h0000, 4'hF, 4'b0010, 4'b1101, S0, 1'b0);
        add_slot(1'b0, 16'h0000, 4'hF, 4'b0010, 4'b1011, S0, 1'b1);
        add_slot(1'b0, 16'h0000, 4'hF, 4'b0010, 4'b0111, S0, 1'b1);
        // Frames 6-8: cover the rest of the decoder table
        add_slot(1'b1, 16'hD6E4, 4'hF, 4'h0, 4'b1110, S4, 1'b1);
        add_slot(1'b0, 16'h0000, 4'hF, 4'h0, 4'b1101, SE, 1'b1);
        add_slot(1'b1, 16'hB5C9, 4'hF, 4'h0, 4'b1011, S6, 1'b1);
        add_slot(1'b0, 16'h0000, 4'hF, 4'h0, 4'b0111, SD, 1'b1);
        add_slot(1'b0, 16'h0000, 4'hF, 4'h0, 4'b1110, S9, 1'b1);
        add_slot(1'b0, 16'h0000, 4'hF, 4'h0, 4'b1101, SC, 1'b1);
        add_slot(1'b0, 16'h0000, 4'hF, 4'h0, 4'b1011, S5, 1'b1);
        add_slot(1'b0, 16'h0000, 4'hF, 4'h0, 4'b0111, SB, 1'b1);
        add_slot(1'b1, 16'h7320, 4'hF, 4'h0, 4'b1110, S0, 1'b1);
        add_slot(1'b0, 16'h0000, 4'hF, 4'h0, 4'b1101, S2, 1'b1);
        add_slot(1'b0, 16'h0000, 4'hF, 4'h0, 4'b1011, S3, 1'b1);
        add_slot(1'b0, 16'h0000, 4'hF, 4'h0, 4'b0111, S7, 1'b1);

        reset    = 1'b1;
        load     = 1'b0;
        value    = 16'h0000;
        digit_en = 4'hF;
        dp_in    = 4'h0;

        tick();
        check("reset_edge1", {an, seg, dp}, {4'b1111, OFF, 1'b1});
        tick();
        check("reset_edge2", {an, seg, dp}, {4'b1111, OFF, 1'b1});
        reset = 1'b0;
        #2;
        check("post_release_blank", {an, seg, dp}, {4'b1111, OFF, 1'b1});

        for (int i = 0; i < vecs.size(); i++) begin
            load     = vecs[i].ld;
            value    = vecs[i].val;
            digit_en = vecs[i].en;
            dp_in    = vecs[i].dpi;
            tick();
            check($sformatf("row%0d", i), {an, seg, dp},
                  {vecs[i].e_an, vecs[i].e_seg, vecs[i].e_dp});
            zeros = 0;
            for (int b = 0; b < 4; b++) if (an[b] == 1'b0) zeros++;
            checks++;
            if (zeros > 1) begin
                errors++;
                $display("FAIL onehot_row%0d: got an=%b want at most one low", i, an);
            end
        end

        // Reset while digit 2 is lit
        load     = 1'b0;
        digit_en = 4'hF;
        dp_in    = 4'h0;
        for (int k = 0; k < 9; k++) tick();
        check("pre_reset_digit2", {an, seg, dp}, {4'b1011, S3, 1'b1});
        reset = 1'b1;
        tick();
        check("midrun_reset", {an, seg, dp}, {4'b1111, OFF, 1'b1});
        reset = 1'b0;
        #2;
        check("midrun_release_blank", {an, seg, dp}, {4'b1111, OFF, 1'b1});
        tick();
        check("after_reset_digit0", {an, seg, dp}, {4'b1110, S0, 1'b1});
        for (int k = 0; k < 4; k++) tick();
        check("after_reset_digit1", {an, seg, dp}, {4'b1101, S0, 1'b1});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
